// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from the timing generator to the renderer.
//   hsync, vsync      : sync outputs at their configured polarity
//   display_active    : high inside the visible area
//   pixel_x, pixel_y  : visible coordinates, 0 outside the visible area
//   tile_x, tile_y    : pixel coordinates divided by the tile size
//   line_start        : one-clock pulse on the first clock of every line
//   frame_start       : one-clock pulse at the first clock of a frame
//   vblank_start      : one-clock pulse at the first blanking line
//   frame_count       : frames started since reset, wraps 255 -> 0
interface video_timing_gen_if #(
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned TILE_LOG2 = 4
) ();

  localparam int unsigned TILE_W = CNT_W - TILE_LOG2;

  logic              hsync;
  logic              vsync;
  logic              display_active;
  logic [CNT_W-1:0]  pixel_x;
  logic [CNT_W-1:0]  pixel_y;
  logic [TILE_W-1:0] tile_x;
  logic [TILE_W-1:0] tile_y;
  logic              line_start;
  logic              frame_start;
  logic              vblank_start;
  logic [7:0]        frame_count;

  modport master (
    output hsync, vsync, display_active, pixel_x, pixel_y, tile_x, tile_y,
           line_start, frame_start, vblank_start, frame_count
  );

  modport slave (
    input  hsync, vsync, display_active, pixel_x, pixel_y, tile_x, tile_y,
           line_start, frame_start, vblank_start, frame_count
  );

endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator. Walks a horizontal/vertical counter
// pair over the full line/frame and registers sync, visible-area, coordinate
// and strobe outputs one clock after the counter state they describe.
//   vga_clk   : pixel clock
//   rst_n     : synchronous active-low reset
//   timing_en : 1 = run, 0 = hold in soft reset (frame_count retained)
//   vt        : timing bundle (master side), see video_timing_gen_if
module video_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned TILE_LOG2 = 4
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               timing_en,
  video_timing_gen_if.master vt
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic [CNT_W-1:0] px_c;
  logic [CNT_W-1:0] py_c;
  logic             active_c;
  logic             hsync_c;
  logic             vsync_c;
  logic             line_c;
  logic             frame_c;
  logic             vblank_c;
  logic [7:0]       frame_cnt_q;

  // Counter advance and decode of the current (h,v) into next output values.
  always_comb begin
    h_nxt = h_cnt + CNT_W'(1);
    v_nxt = v_cnt;
    if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
      h_nxt = '0;
      v_nxt = (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + CNT_W'(1);
    end

    active_c = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
    px_c     = active_c ? h_cnt : '0;
    py_c     = active_c ? v_cnt : '0;

    hsync_c  = ((h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END)))
               ? HSYNC_POL : ~HSYNC_POL;
    vsync_c  = ((v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END)))
               ? VSYNC_POL : ~VSYNC_POL;

    line_c   = (h_cnt == '0);
    frame_c  = line_c && (v_cnt == '0);
    vblank_c = line_c && (v_cnt == CNT_W'(V_VISIBLE));
  end

  // Reset and soft reset share one path; only hard reset clears frame_count.
  always_ff @(posedge vga_clk) begin
    if (!rst_n || !timing_en) begin
      h_cnt             <= '0;
      v_cnt             <= '0;
      vt.hsync          <= ~HSYNC_POL;
      vt.vsync          <= ~VSYNC_POL;
      vt.display_active <= 1'b0;
      vt.pixel_x        <= '0;
      vt.pixel_y        <= '0;
      vt.tile_x         <= '0;
      vt.tile_y         <= '0;
      vt.line_start     <= 1'b0;
      vt.frame_start    <= 1'b0;
      vt.vblank_start   <= 1'b0;
      if (!rst_n) begin
        frame_cnt_q <= '0;
      end
    end else begin
      h_cnt             <= h_nxt;
      v_cnt             <= v_nxt;
      vt.hsync          <= hsync_c;
      vt.vsync          <= vsync_c;
      vt.display_active <= active_c;
      vt.pixel_x        <= px_c;
      vt.pixel_y        <= py_c;
      vt.tile_x         <= px_c[CNT_W-1:TILE_LOG2];
      vt.tile_y         <= py_c[CNT_W-1:TILE_LOG2];
      vt.line_start     <= line_c;
      vt.frame_start    <= frame_c;
      vt.vblank_start   <= vblank_c;
      // Counted on the same edge that registers frame_start.
      if (frame_c) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign vt.frame_count = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen in a small mode (H 8/2/3/2, V 4/1/2/1,
// hsync active-high). The reference model derives (h,v) from the number of
// running clocks since the last reset/soft reset using division and modulo.
module tb_video_timing_gen;

  localparam int unsigned HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VV = 4, VF = 1, VS = 2, VB = 1;
  localparam bit          HPOL = 1'b1;
  localparam bit          VPOL = 1'b0;
  localparam int unsigned CW = 5;
  localparam int unsigned TL = 2;
  localparam int unsigned TW = CW - TL;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic [TW-1:0] tx;
    logic [TW-1:0] ty;
    logic          ls;
    logic          fs;
    logic          vb;
    logic [7:0]    fc;
  } vt_t;

  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic timing_en = 1'b0;

  video_timing_gen_if #(.CNT_W(CW), .TILE_LOG2(TL)) vt ();

  video_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CNT_W(CW), .TILE_LOG2(TL)
  ) dut (
    .vga_clk(vga_clk),
    .rst_n(rst_n),
    .timing_en(timing_en),
    .vt(vt.master)
  );

  always #5 vga_clk = ~vga_clk;

  vt_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  stim_done = 1'b0;

  // Model state: running clocks in the current segment and frame count at its start.
  int         t_run  = 0;
  int         seg_fc = 0;
  logic [7:0] last_fc = 8'd0;

  function automatic vt_t reset_value(input logic [7:0] fc);
    vt_t e;
    e    = '0;
    e.hs = ~HPOL;
    e.vs = ~VPOL;
    e.fc = fc;
    return e;
  endfunction

  function automatic vt_t model_at(input int t, input int base_fc);
    vt_t e;
    int  h, v;
    h = t % HT;
    v = (t / HT) % VT;
    e    = '0;
    e.de = (h < HV) && (v < VV);
    e.px = e.de ? CW'(h) : '0;
    e.py = e.de ? CW'(v) : '0;
    e.tx = TW'(e.px / (2 ** TL));
    e.ty = TW'(e.py / (2 ** TL));
    e.hs = (h >= HV + HF && h < HV + HF + HS) ? HPOL : ~HPOL;
    e.vs = (v >= VV + VF && v < VV + VF + VS) ? VPOL : ~VPOL;
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    e.vb = (h == 0) && (v == VV);
    e.fc = 8'((base_fc + t / FRAME + 1) % 256);
    return e;
  endfunction

  // Drive inputs for the next rising edge and queue the outputs it must produce.
  task automatic step(input logic r, input logic en);
    vt_t e;
    @(negedge vga_clk);
    rst_n     = r;
    timing_en = en;
    if (!r) begin
      e       = reset_value(8'd0);
      last_fc = 8'd0;
      seg_fc  = 0;
      t_run   = 0;
    end else if (!en) begin
      e      = reset_value(last_fc);
      seg_fc = int'(last_fc);
      t_run  = 0;
    end else begin
      e       = model_at(t_run, seg_fc);
      last_fc = e.fc;
      t_run++;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: sample just after each rising edge and compare against the queue head.
  initial begin
    vt_t a, e;
    forever begin
      @(posedge vga_clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a.hs = vt.hsync;       a.vs = vt.vsync;       a.de = vt.display_active;
        a.px = vt.pixel_x;     a.py = vt.pixel_y;
        a.tx = vt.tile_x;      a.ty = vt.tile_y;
        a.ls = vt.line_start;  a.fs = vt.frame_start; a.vb = vt.vblank_start;
        a.fc = vt.frame_count;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got hs=%b vs=%b de=%b px=%0d py=%0d tx=%0d ty=%0d ls=%b fs=%b vb=%b fc=%0d; want hs=%b vs=%b de=%b px=%0d py=%0d tx=%0d ty=%0d ls=%b fs=%b vb=%b fc=%0d",
                   $time, a.hs, a.vs, a.de, a.px, a.py, a.tx, a.ty, a.ls, a.fs, a.vb, a.fc,
                   e.hs, e.vs, e.de, e.px, e.py, e.tx, e.ty, e.ls, e.fs, e.vb, e.fc);
        end
      end
    end
  end

  initial begin
    int unsigned len;
    // Hard reset, then release: first output cycle must be (0,0) with frame_count 1.
    repeat (3) step(1'b0, 1'b0);
    repeat (2 * FRAME) step(1'b1, 1'b1);

    // Soft reset mid-frame (a few clocks), then resume.
    repeat (FRAME / 2 + 3) step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    repeat (FRAME) step(1'b1, 1'b1);

    // Long run across the 255 -> 0 frame_count wrap with rare random soft resets.
    for (int i = 0; i < 260 * int'(FRAME); i++) begin
      if ($urandom_range(0, 599) == 0) begin
        len = $urandom_range(1, 6);
        repeat (len) step(1'b1, 1'b0);
      end else begin
        step(1'b1, 1'b1);
      end
    end

    // Random mix of hard resets, soft resets and running.
    for (int i = 0; i < 3000; i++) begin
      len = $urandom_range(0, 299);
      if (len == 0)      step(1'b0, 1'($urandom_range(0, 1)));
      else if (len < 3)  step(1'b1, 1'b0);
      else               step(1'b1, 1'b1);
    end

    // Let the monitor drain; an undrained queue means the monitor missed edges.
    repeat (3) @(negedge vga_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #5_000_000;
    if (!stim_done) begin
      $display("FAIL timeout: stimulus not complete at %0t", $time);
      $fatal(1, "timeout");
    end
  end

endmodule
